// File: rtl/pipe_stage_reg_pkg.sv
// Shared stage-bundle geometry, nop/RNONE encodings and the stage FSM encoding
// for the parametrised Y86 pipeline stage register.
package pipe_stage_reg_pkg;

  localparam int NIBBLE_W = 4;
  localparam int WORD_W   = 64;

  // {icode, valE, dstE, dstM}
  localparam int STAGE_W  = NIBBLE_W + WORD_W + 2 * NIBBLE_W;

  localparam logic [NIBBLE_W-1:0] INOP  = 4'h1;
  localparam logic [NIBBLE_W-1:0] RNONE = 4'hF;

  localparam logic [STAGE_W-1:0] BUBBLE_DEFAULT = {INOP, {WORD_W{1'b0}}, RNONE, RNONE};

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One WIDTH-bit bundle slot: clear to a fixed value, or load, otherwise hold.
module pipe_stage_reg_slot #(
  parameter int               WIDTH     = 76,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= CLR_VALUE;
    end else if (ld) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, hazard stall/bubble and an
// optional second (skid) entry so in_ready need not depend on out_ready.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int               WIDTH        = STAGE_W,
  parameter logic [WIDTH-1:0] BUBBLE_VALUE = WIDTH'(BUBBLE_DEFAULT),
  parameter bit               SKID         = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             bubble_i,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  stage_state_e     state_p1;
  stage_state_e     state_nxt;
  logic             main_ld;
  logic             main_from_skid;
  logic             skid_ld;
  logic             slot_clr;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_p1;

  // Stall forces both handshakes low, so a stalled edge naturally holds everything.
  assign out_valid = (state_p1 != ST_EMPTY) & ~stall_i;
  assign in_ready  = SKID ? (~rst & ~stall_i & (state_p1 != ST_SKID))
                          : (~rst & ~stall_i & ((state_p1 == ST_EMPTY) | out_ready));
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = state_p1;
  assign slot_clr  = rst | bubble_i;
  assign main_d    = main_from_skid ? skid_p1 : in_data;

  always_comb begin
    state_nxt      = state_p1;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    unique case (state_p1)
      ST_EMPTY: begin
        if (in_fire) begin
          state_nxt = ST_FULL;
          main_ld   = 1'b1;
        end
      end
      ST_FULL: begin
        if (in_fire && out_fire) begin
          main_ld = 1'b1;
        end else if (in_fire && SKID) begin
          state_nxt = ST_SKID;
          skid_ld   = 1'b1;
        end else if (out_fire) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (out_fire) begin
          state_nxt      = ST_FULL;
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Stage boundary: control state and the two bundle slots
  always_ff @(posedge clk) begin
    if (rst || bubble_i) begin
      state_p1 <= ST_EMPTY;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  pipe_stage_reg_slot #(
    .WIDTH    (WIDTH),
    .CLR_VALUE(BUBBLE_VALUE)
  ) u_main (
    .clk(clk),
    .clr(slot_clr),
    .ld (main_ld),
    .d  (main_d),
    .q  (out_data)
  );

  pipe_stage_reg_slot #(
    .WIDTH    (WIDTH),
    .CLR_VALUE(BUBBLE_VALUE)
  ) u_skid (
    .clk(clk),
    .clr(slot_clr),
    .ld (skid_ld),
    .d  (in_data),
    .q  (skid_p1)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: a SKID=1 instance driven from a vector table, and a SKID=0
// instance exercised by a short hand-written sequence.
module tb_pipe_stage_reg;

  localparam int W = 76;
  localparam logic [W-1:0] BV = {4'h1, 64'h0, 4'hF, 4'hF};

  logic         clk;
  logic         rst;

  logic         stall_i, bubble_i, in_valid, out_ready;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  logic         s0_stall, s0_bubble, s0_in_valid, s0_out_ready;
  logic [W-1:0] s0_in_data;
  logic         s0_in_ready, s0_out_valid;
  logic [W-1:0] s0_out_data;
  logic [1:0]   s0_occupancy;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_reg #(.WIDTH(W), .BUBBLE_VALUE(BV), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .bubble_i(bubble_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_reg #(.WIDTH(W), .BUBBLE_VALUE(BV), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .stall_i(s0_stall), .bubble_i(s0_bubble),
    .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
    .occupancy(s0_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         stall;
    logic         bub;
    logic         e_ov;
    logic         e_ir;
    logic [W-1:0] e_od;
    logic [1:0]   e_occ;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [W-1:0] dv(input int n);
    return {4'h6, 64'hD000_0000_0000_0000 + 64'(n), 4'h3, 4'h4};
  endfunction

  task automatic add(input logic iv, input logic [W-1:0] d, input logic ordy,
                     input logic stall, input logic bub, input logic e_ov,
                     input logic e_ir, input logic [W-1:0] e_od, input logic [1:0] e_occ);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.stall = stall; v.bub = bub;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_od = e_od; v.e_occ = e_occ;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // streaming, out_ready=1: each bundle visible one cycle after its push
    add(1, dv(1), 1, 0, 0, 0, 1, BV, 0);
    for (int k = 2; k <= 8; k++) add(1, dv(k), 1, 0, 0, 1, 1, dv(k-1), 1);
    add(0, '0, 1, 0, 0, 1, 1, dv(8), 1);
    add(0, '0, 1, 0, 0, 0, 1, dv(8), 0);
    // backpressure into skid, then drain
    add(1, dv(1), 0, 0, 0, 0, 1, dv(8), 0);
    add(1, dv(2), 0, 0, 0, 1, 1, dv(1), 1);
    add(1, dv(9), 0, 0, 0, 1, 0, dv(1), 2);
    add(0, '0,    1, 0, 0, 1, 0, dv(1), 2);
    add(0, '0,    1, 0, 0, 1, 1, dv(2), 1);
    add(0, '0,    1, 0, 0, 0, 1, dv(2), 0);
    // stall while FULL with D3 and D4 waiting
    add(1, dv(3), 0, 0, 0, 0, 1, dv(2), 0);
    for (int k = 0; k < 3; k++) add(1, dv(4), 1, 1, 0, 0, 0, dv(3), 1);
    add(1, dv(4), 1, 0, 0, 1, 1, dv(3), 1);
    add(0, '0,    1, 0, 0, 1, 1, dv(4), 1);
    add(0, '0,    1, 0, 0, 0, 1, dv(4), 0);
    // bubble+stall from SKID state: D5/D6 never leave
    add(1, dv(5), 0, 0, 0, 0, 1, dv(4), 0);
    add(1, dv(6), 0, 0, 0, 1, 1, dv(5), 1);
    add(1, dv(7), 1, 1, 1, 0, 0, dv(5), 2);
    add(0, '0,    1, 0, 0, 0, 1, BV, 0);
    add(0, '0,    1, 0, 0, 0, 1, BV, 0);
    // bubble from FULL drops the bundle offered that cycle
    add(1, dv(7), 0, 0, 0, 0, 1, BV, 0);
    add(1, dv(8), 0, 0, 1, 1, 1, dv(7), 1);
    add(0, '0,    0, 0, 0, 0, 1, BV, 0);

    // reset held 2 cycles with a bundle offered
    rst = 1; stall_i = 0; bubble_i = 0; in_valid = 1; out_ready = 1;
    in_data = {19{4'hA}};
    s0_stall = 0; s0_bubble = 0; s0_in_valid = 0; s0_out_ready = 0; s0_in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_out_valid", W'(out_valid), W'(1'b0));
    check("rst_out_data",  out_data, BV);
    check("rst_occupancy", W'(occupancy), W'(2'd0));
    check("rst_in_ready",  W'(in_ready), W'(1'b0));
    rst = 0; in_valid = 0;
    #1;
    check("post_rst_in_ready", W'(in_ready), W'(1'b1));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
      stall_i = tbl[i].stall; bubble_i = tbl[i].bub;
      #1;
      check($sformatf("v%0d_out_valid", i), W'(out_valid), W'(tbl[i].e_ov));
      check($sformatf("v%0d_in_ready", i),  W'(in_ready),  W'(tbl[i].e_ir));
      check($sformatf("v%0d_out_data", i),  out_data, tbl[i].e_od);
      check($sformatf("v%0d_occupancy", i), W'(occupancy), W'(tbl[i].e_occ));
    end

    // reset asserted mid-transfer while FULL
    @(negedge clk);
    in_valid = 1; in_data = dv(9); out_ready = 0; stall_i = 0; bubble_i = 0;
    @(negedge clk);
    rst = 1; in_data = dv(10); out_ready = 1;
    #1;
    check("midrst_in_ready", W'(in_ready), W'(1'b0));
    @(negedge clk); #1;
    check("midrst_out_valid", W'(out_valid), W'(1'b0));
    check("midrst_out_data",  out_data, BV);
    check("midrst_occupancy", W'(occupancy), W'(2'd0));
    rst = 0; in_valid = 0;

    // SKID=0 instance: in_ready follows out_ready combinationally when FULL
    @(negedge clk);
    s0_in_valid = 1; s0_in_data = dv(1); s0_out_ready = 0;
    #1;
    check("s0_empty_in_ready", W'(s0_in_ready), W'(1'b1));
    @(negedge clk);
    s0_in_data = dv(2);
    #1;
    check("s0_full_in_ready_lo", W'(s0_in_ready), W'(1'b0));
    check("s0_full_out_data",    s0_out_data, dv(1));
    check("s0_full_occupancy",   W'(s0_occupancy), W'(2'd1));
    s0_out_ready = 1;
    #1;
    check("s0_full_in_ready_hi", W'(s0_in_ready), W'(1'b1));
    @(negedge clk);
    s0_in_valid = 0;
    #1;
    check("s0_replace_out_data",  s0_out_data, dv(2));
    check("s0_replace_out_valid", W'(s0_out_valid), W'(1'b1));
    check("s0_replace_occupancy", W'(s0_occupancy), W'(2'd1));
    @(negedge clk); #1;
    check("s0_drain_out_valid", W'(s0_out_valid), W'(1'b0));
    check("s0_drain_occupancy", W'(s0_occupancy), W'(2'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
